// File: rtl/oled_fb_arbiter.sv
// oled_fb_arbiter: block-RAM framebuffer shared between the OLED scan core's
// pixel fetch (high priority) and a valid/ready writer port.
// Optional build macro: OLED_FB_DOUBLE_BUFFER_EN (front/back banks, swap_req/swap_done).
module oled_fb_arbiter #(
  parameter int c_color_bits = 16,
  parameter int c_x_size     = 128,
  parameter int c_y_size     = 128,
  parameter int c_x_bits     = $clog2(c_x_size),
  parameter int c_y_bits     = $clog2(c_y_size),
  parameter int c_addr_bits  = c_y_bits + c_x_bits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [c_x_bits-1:0]     x,
  input  logic [c_y_bits-1:0]     y,
  input  logic                    next_pixel,
  output logic [c_color_bits-1:0] color,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [c_addr_bits-1:0]  wr_addr,
  input  logic [c_color_bits-1:0] wr_data,
  output logic                    frame_start,
  output logic [7:0]              frame_count,
  output logic                    overrun
`ifdef OLED_FB_DOUBLE_BUFFER_EN
  ,
  input  logic                    swap_req,
  output logic                    swap_done
`endif
);

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  localparam int c_ram_bits = c_addr_bits + 1;
`else
  localparam int c_ram_bits = c_addr_bits;
`endif

  localparam logic [1:0] PRIME      = 2'd0;
  localparam logic [1:0] IDLE       = 2'd1;
  localparam logic [1:0] FETCH_WAIT = 2'd2;

  logic [1:0]              state;
  logic                    fetch_pend;
  logic                    fetch_go;
  logic                    rd_en;
  logic                    wr_en;
  logic                    boundary;
  logic                    busy;
  logic [c_ram_bits-1:0]   rd_addr;
  logic [c_ram_bits-1:0]   wr_ram_addr;
  logic [c_color_bits-1:0] rd_data;
  logic [c_color_bits-1:0] mem [0:(1<<c_ram_bits)-1];

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  logic front;
  logic front_eff;
  logic swap_pend;
  logic swap_fire;
`endif

  // Arbitration: a pixel read (scan request or deferred overrun fetch) always beats the writer
  always_comb begin
    fetch_go = !reset && ((state == IDLE && next_pixel) || fetch_pend);
    rd_en    = fetch_go || (!reset && state == PRIME);
    busy     = (state != IDLE) || fetch_pend;
    boundary = fetch_go && (x == '0) && (y == '0);
    wr_ready = !reset && (state != PRIME) && !fetch_go;
    wr_en    = wr_valid && wr_ready;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
    // The swap takes effect in the boundary cycle so that very fetch reads the new front bank
    swap_fire   = boundary && (swap_pend || swap_req);
    front_eff   = front ^ swap_fire;
    rd_addr     = (state == PRIME) ? {front, {c_addr_bits{1'b0}}} : {front_eff, y, x};
    wr_ram_addr = {~front, wr_addr};
`else
    rd_addr     = (state == PRIME) ? '0 : {y, x};
    wr_ram_addr = wr_addr;
`endif
  end

  // Single-port framebuffer: one read or one write per cycle, 1-cycle read latency
  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data <= mem[rd_addr];
    else if (wr_en)
      mem[wr_ram_addr] <= wr_data;
  end

  // Fetch sequencer, color register, overrun and frame tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PRIME;
      fetch_pend  <= 1'b0;
      color       <= '0;
      overrun     <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= rd_en ? FETCH_WAIT : IDLE;
      if (state == FETCH_WAIT)
        color <= rd_data;
      // A request arriving while a read is in flight is replayed next cycle with the then-current x/y
      if (next_pixel && busy) begin
        overrun    <= 1'b1;
        fetch_pend <= 1'b1;
      end else if (fetch_go) begin
        fetch_pend <= 1'b0;
      end
      frame_start <= boundary;
      if (boundary)
        frame_count <= frame_count + 8'd1;
    end
  end

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  // Bank selection: collapse swap requests into one swap at the next frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      front     <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      front     <= front_eff;
      swap_done <= swap_fire;
      swap_pend <= swap_fire ? 1'b0 : (swap_pend || swap_req);
    end
  end
`endif

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Directed self-checking bench for oled_fb_arbiter (default single-bank build).
module tb_oled_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  x = '0;
  logic [6:0]  y = '0;
  logic        next_pixel = 1'b0;
  logic [15:0] color;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [13:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        frame_start;
  logic [7:0]  frame_count;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  oled_fb_arbiter #(.c_color_bits(16), .c_x_size(128), .c_y_size(128)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .next_pixel(next_pixel), .color(color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] data_of(input int a);
    return 16'(a * 3) + 16'h1000;
  endfunction

  task automatic write_word(input logic [13:0] a, input logic [15:0] d);
    bit done = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 8 && !done; i++) begin
      #3;
      if (wr_ready) done = 1;
      tick;
    end
    wr_valid = 1'b0;
    if (!done) check("write_timeout", 0, 1);
  endtask

  // Leaves the caller in cycle N+1 of the fetch
  task automatic pulse(input logic [6:0] xx, input logic [6:0] yy);
    x = xx;
    y = yy;
    next_pixel = 1'b1;
    tick;
    next_pixel = 1'b0;
  endtask

  task automatic fetch_check(input string tag, input int a, input logic [15:0] exp);
    logic [13:0] av;
    av = 14'(a);
    pulse(av[6:0], av[13:7]);
    tick;
    check(tag, color, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int addr, stalls, accepted;
    bit adv;

    tick; tick;
    reset = 1'b0;
    tick; tick; tick;
    write_word(14'd0, 16'hF800);
    write_word(14'd1, 16'h07E0);

    // Reset state
    reset = 1'b1;
    tick;
    check("rst_color", color, 16'h0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overrun", overrun, 0);

    // Prime read of address 0
    reset = 1'b0;
    #1;
    check("prime_wr_ready", wr_ready, 0);
    tick;
    check("fw_wr_ready", wr_ready, 1);
    tick; tick;
    check("prime_color", color, 16'hF800);
    check("prime_overrun", overrun, 0);

    // Single pixel fetch of {y=0,x=1}
    x = 7'd1; y = 7'd0; next_pixel = 1'b1;
    #1;
    check("np_wr_ready", wr_ready, 0);
    tick;
    next_pixel = 1'b0;
    check("fetch_n1_color", color, 16'hF800);
    tick;
    check("fetch_n2_color", color, 16'h07E0);

    // Writer contention: continuous writes with three interleaved pixel fetches
    addr = 200; stalls = 0; accepted = 0;
    for (int i = 0; i < 96; i++) begin
      wr_valid   = 1'b1;
      wr_addr    = 14'(addr);
      wr_data    = data_of(addr);
      next_pixel = (i % 32 == 5);
      x = 7'd0; y = 7'd1;
      #3;
      adv = wr_ready;
      if (adv) accepted++; else stalls++;
      tick;
      if (adv) addr++;
    end
    wr_valid = 1'b0;
    next_pixel = 1'b0;
    check("cont_stalls", stalls, 3);
    check("cont_accepted", accepted, 93);
    fetch_check("rb_200", 200, 16'h1258);
    fetch_check("rb_250", 250, 16'h12EE);
    fetch_check("rb_292", 292, 16'h136C);
    check("pre_frame_count", frame_count, 0);

    // Frame boundaries
    pulse(7'd0, 7'd0);
    check("f1_start", frame_start, 1);
    check("f1_count", frame_count, 1);
    tick;
    check("f1_start_clr", frame_start, 0);
    pulse(7'd5, 7'd3);
    check("nb_start", frame_start, 0);
    tick;
    pulse(7'd127, 7'd127);
    tick;
    pulse(7'd0, 7'd0);
    check("f2_start", frame_start, 1);
    check("f2_count", frame_count, 2);
    tick;
    for (int i = 0; i < 254; i++) begin
      pulse(7'd0, 7'd0);
      tick;
    end
    check("wrap_count", frame_count, 0);
    check("no_overrun_yet", overrun, 0);

    // Overrun: back-to-back requests, second coordinate wins
    write_word(14'd300, 16'hABCD);
    write_word(14'd301, 16'h1357);
    x = 7'd44; y = 7'd2; next_pixel = 1'b1;
    tick;
    x = 7'd45;
    tick;
    next_pixel = 1'b0;
    check("ovr_set", overrun, 1);
    tick; tick;
    check("ovr_color", color, 16'h1357);
    tick; tick; tick;
    check("ovr_sticky", overrun, 1);

    // Reset clears sticky and counters
    reset = 1'b1;
    tick;
    check("rst2_overrun", overrun, 0);
    check("rst2_color", color, 16'h0);
    reset = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_fb_arbiter.md
Name: oled_fb_arbiter

Overview:
- Framebuffer-backed pixel source for the SPI OLED XY scan core (SSD1331/SSD1351 family, 128x128 default).
- Owns one single-port block-RAM framebuffer and arbitrates it between two requesters: the scan core's pixel fetch (high priority) and a valid/ready writer port (CPU, pattern generator, UART loader).
- Sequences per-pixel prefetch so `color` is stable long before the scan core samples it.
- Tracks frame boundaries and frame count.

Parameters:
- c_color_bits, 16, pixel width; must match the scan core (8 or 16).
- c_x_size, 128, screen width in pixels.
- c_y_size, 128, screen height in pixels.
- c_x_bits, $clog2(c_x_size), X coordinate width.
- c_y_bits, $clog2(c_y_size), Y coordinate width.
- c_addr_bits, c_y_bits+c_x_bits, framebuffer address width; address = {y,x}.

Ports:
- clk  in  1  single system clock (same clock as scan core)
- reset  in  1  synchronous, active-high reset
- x  in  c_x_bits  scan core X of the pixel to be sent next
- y  in  c_y_bits  scan core Y of the pixel to be sent next
- next_pixel  in  1  scan core 1-cycle pulse; x/y already hold the new coordinate
- color  out  c_color_bits  registered pixel color for the current x/y
- wr_valid  in  1  writer request
- wr_ready  out  1  writer grant; a write occurs when wr_valid && wr_ready
- wr_addr  in  c_addr_bits  writer address {y,x}
- wr_data  in  c_color_bits  writer pixel data
- frame_start  out  1  1-cycle pulse when the scan wraps to (0,0)
- frame_count  out  8  frames started since reset, wraps 255->0
- overrun  out  1  sticky: next_pixel arrived while a fetch was still in flight

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: color=0, wr_ready=0, frame_start=0, frame_count=0, overrun=0, FSM=PRIME. Framebuffer contents are not cleared. Reset mid-fetch or mid-write aborts it; a write accepted in the reset cycle is discarded.
- RAM: single-port, 1-cycle synchronous read; one access per cycle, either a read or a write.
- FSM states:
  - PRIME: first cycle after reset. Issue read of address 0 (first pixel is consumed before any next_pixel). Go to FETCH_WAIT.
  - IDLE: no read pending; wr_ready=1 unless next_pixel=1 this cycle.
  - FETCH_WAIT: RAM output valid. Load color from RAM, go to IDLE. wr_ready=1 in this state.
- Fetch rule: in IDLE with next_pixel=1 at cycle N:
  - Read {y,x} in cycle N; wr_ready=0 in cycle N (display has priority).
  - RAM data returns in cycle N+1; color is updated at the end of N+1 and is valid from N+2.
  - The scan core samples color at least 15 cycles later, so the budget is met.
- Writer: a write is accepted only in cycles where no read is issued. Max writer stall is 1 cycle per pixel fetch. wr_ready is combinational from next_pixel/state; the writer must hold wr_addr/wr_data while wr_valid && !wr_ready.
- next_pixel while FSM != IDLE (PRIME or FETCH_WAIT):
  - Set overrun=1 (sticky until reset).
  - The new fetch is issued in the next cycle, using x/y as they are then.
- Frame boundary: next_pixel with x==0 && y==0 →
  - frame_start=1 in cycle N+1.
  - frame_count increments in cycle N+1.
- Write and fetch to the same address in the same cycle cannot occur (the read wins). A write landing one cycle before a fetch of that address is returned by the fetch (new data).

Optional Feature:
- Macro: OLED_FB_DOUBLE_BUFFER_EN.
- With it defined:
  - RAM depth doubles; bank bit is the address MSB.
  - Extra ports: swap_req (in, 1) and swap_done (out, 1, 1-cycle pulse).
  - Display reads the front bank; writer writes the back bank (~front). front resets to 0.
  - A swap_req pulse sets a pending flag. On the next frame-boundary fetch (x==0,y==0), front toggles in the same cycle, so that fetch already reads the new front bank. swap_done pulses together with frame_start.
  - Multiple swap_req pulses before a boundary give one swap.
- Without it: single bank; no swap ports.

Test Plan:
- Prime after reset: write 0xF800 to address 0 before reset release, then deassert reset → color=0xF800 by cycle 3 after reset; overrun=0.
- Pixel fetch: RAM[{y=0,x=1}]=0x07E0, pulse next_pixel with x=1 at cycle N → wr_ready=0 at N, color=0x07E0 at N+2.
- Writer contention: wr_valid held continuously with incrementing addr while next_pixel pulses every 32 cycles → exactly one stall cycle per pulse; all writes land; RAM readback matches.
- Frame wrap: drive the full 128x128 scan (next_pixel every 32 cycles) → frame_start pulses once per frame; frame_count goes 0→1→2.
- Overrun: pulse next_pixel in two consecutive cycles → overrun=1 and stays 1; color reflects the second coordinate.
- With OLED_FB_DOUBLE_BUFFER_EN: fill bank1 with 0x001F, pulse swap_req mid-frame → color keeps bank0 data until the (0,0) fetch, then 0x001F; swap_done is coincident with frame_start.
